decode_stage_hz: RTL and testbench
==================================

// Module: decode_stage_hz
// PURPOSE
//  Parametrised ID stage with hazard handling: control decode, register file, immediate extend, ID/EX register.
//  Sits between IF/ID and EX. Adds over the plain ID stage: load-use stall, branch flush, EX back-pressure hold,
//  valid tracking, and configurable data width / register count.
// PARAMETERS
//  XLEN    32  datapath/PC width; legal 32 or 64; 32-bit immediate sign-extended to XLEN
//  REG_AW  5   register index width; 5 -> 32 regs (RV32I), 4 -> 16 regs (RV32E)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous, active-low reset
//  InstrD       in   32      instruction from IF/ID
//  PCD          in   XLEN    PC of InstrD
//  ValidD       in   1       InstrD is a real instruction (0 = bubble)
//  RegWriteW    in   1       writeback enable
//  RDW          in   REG_AW  writeback destination
//  ResultW      in   XLEN    writeback data
//  FlushE       in   1       taken branch/jump in EX: kill the instruction entering EX
//  HoldE        in   1       EX busy: freeze ID/EX
//  StallD       out  1       hold PC and IF/ID this cycle
//  ValidE       out  1       EX holds a real instruction
//  BranchE, ResultSrcE, MemWriteE, RegWriteE, ALUSrcE  out 1 each  registered control
//  ALUControlE  out  4       registered ALU op
//  RS1E, RS2E, RDE  out  REG_AW  registered register indices
//  RD1E, RD2E   out  XLEN    registered operands
//  ImmExtE      out  XLEN    registered immediate
//  PCE          out  XLEN    registered PC
// BEHAVIOUR
//  - Decode: Control_Unit and Extend on InstrD, combinational. rs1/rs2/rd = InstrD[19:15]/[24:20]/[11:7],
//    low REG_AW bits only.
//  - Regfile: 2**REG_AW x XLEN. x0 reads 0 and ignores writes. Written at posedge when RegWriteW && RDW!=0.
//    Reads are combinational. Reset clears all entries to 0.
//  - LoadUse = ValidE && ResultSrcE && RegWriteE && RDE!=0 && (RDE==rs1D || RDE==rs2D).
//    Both sources are always compared, regardless of whether the opcode uses rs2.
//  - StallD = (LoadUse || HoldE) && !FlushE. Combinational; this is the only combinational output.
//  - ID/EX update at posedge, in priority order:
//    1 FlushE: bubble.
//    2 HoldE: all E outputs keep their value.
//    3 LoadUse or !ValidD: bubble.
//    4 else: load decoded values; ValidE=1.
//  - Bubble: ValidE, BranchE, ResultSrcE, MemWriteE, RegWriteE, ALUSrcE = 0. All other E fields = 0.
//  - Latency: one cycle from ID to E outputs. A load-use stall inserts exactly one bubble. The stalled
//    instruction re-presents on InstrD the next cycle and then passes.
//  - FlushE together with HoldE: the flush wins; EX takes a bubble.
//  - FlushE together with LoadUse: a bubble; StallD=0, because IF/ID is being redirected anyway.
//  - Reset (async assert, any cycle, including mid-stall): all E outputs and regfile go to 0; ValidE=0.
//    Deassertion is synchronised externally; the first posedge after reset is a normal update.
//  - Widths: RD1/RD2/PC are XLEN bits. ImmExtE = sign-extended Extend output. No arithmetic is done here.
// CONFIGURATION
//  ID_WB_BYPASS_EN defined:
//    A read of a register being written the same cycle (RegWriteW && RDW!=0 && RDW==rsX) returns ResultW.
//  ID_WB_BYPASS_EN undefined:
//    Reads return the stored value (the old value in that cycle).
//    The EX forwarding unit must then cover the W->D distance.
// TESTING
//  1 Reset: rst=0 mid-run -> all E outputs 0 immediately, no posedge needed; rs reads return 0 afterwards.
//  2 Load-use: lw x5 (in E) then add x6,x5,x1 in D -> StallD=1 for one cycle, one bubble (ValidE=0);
//    the next cycle the add reaches E with RS1E=5.
//  3 Flush priority: FlushE=1, HoldE=1, valid addi in D -> next cycle ValidE=0, RegWriteE=0, StallD=0.
//  4 Hold: HoldE=1 for 3 cycles -> E outputs frozen, StallD=1; release -> InstrD loads on the next edge.
//  5 Bypass: RegWriteW=1, RDW=7, ResultW=0xDEADBEEF, rs1D=7 -> RD1E=0xDEADBEEF with ID_WB_BYPASS_EN;
//    old value without it. RDW=0 -> RD1E=0 in both builds.
//  6 RV32E: REG_AW=4, XLEN=64, addi x3,x0,-1 -> ImmExtE=64'hFFFF_FFFF_FFFF_FFFF, RDE=3.

Source files
------------

// File: rtl/decode_stage_hz.sv
// Decode stage with hazard handling: control decode, register file, immediate extend and ID/EX register.
// Optional macro ID_WB_BYPASS_EN: a register being written back this cycle is read as ResultW.
module decode_stage_hz #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       InstrD,
  input  logic [XLEN-1:0]   PCD,
  input  logic              ValidD,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RDW,
  input  logic [XLEN-1:0]   ResultW,
  input  logic              FlushE,
  input  logic              HoldE,
  output logic              StallD,
  output logic              ValidE,
  output logic              BranchE,
  output logic              ResultSrcE,
  output logic              MemWriteE,
  output logic              RegWriteE,
  output logic              ALUSrcE,
  output logic [3:0]        ALUControlE,
  output logic [REG_AW-1:0] RS1E,
  output logic [REG_AW-1:0] RS2E,
  output logic [REG_AW-1:0] RDE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE
);
  localparam int unsigned NREGS = 2 ** REG_AW;

  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7,
                         ALU_SRA = 4'd8, ALU_SLTU = 4'd9;

  typedef struct packed {
    logic              valid;
    logic              branch;
    logic              result_src;
    logic              mem_write;
    logic              reg_write;
    logic              alu_src;
    logic [3:0]        alu_ctrl;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
  } idex_t;

  logic [6:0]        op;
  logic [2:0]        f3;
  logic              f7b5;
  logic [REG_AW-1:0] rs1_d, rs2_d, rd_d;
  logic              reg_write, alu_src, mem_write, result_src, branch;
  logic [1:0]        alu_op;
  logic [2:0]        imm_src;
  logic [3:0]        alu_ctrl;
  logic [31:0]       imm32;
  logic [XLEN-1:0]   rd1_d, rd2_d;
  logic [XLEN-1:0]   regs [NREGS];
  logic              load_use;
  idex_t             d, q;

  assign op    = InstrD[6:0];
  assign f3    = InstrD[14:12];
  assign f7b5  = InstrD[30];
  assign rs1_d = InstrD[15 +: REG_AW];
  assign rs2_d = InstrD[20 +: REG_AW];
  assign rd_d  = InstrD[7 +: REG_AW];

  // Main control decode
  always_comb begin
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    result_src = 1'b0;
    branch     = 1'b0;
    alu_op     = 2'b00;
    imm_src    = IMM_I;
    case (op)
      7'b0000011: begin reg_write = 1'b1; alu_src = 1'b1; result_src = 1'b1; end
      7'b0100011: begin alu_src = 1'b1; mem_write = 1'b1; imm_src = IMM_S; end
      7'b0110011: begin reg_write = 1'b1; alu_op = 2'b10; end
      7'b0010011: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = 2'b10; end
      7'b1100011: begin branch = 1'b1; alu_op = 2'b01; imm_src = IMM_B; end
      7'b1101111: begin reg_write = 1'b1; branch = 1'b1; imm_src = IMM_J; end
      7'b0110111: begin reg_write = 1'b1; alu_src = 1'b1; imm_src = IMM_U; end
      default: ;
    endcase
  end

  // ALU operation decode
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      2'b00: alu_ctrl = ALU_ADD;
      2'b01: alu_ctrl = ALU_SUB;
      default: begin
        case (f3)
          3'b000:  alu_ctrl = (op[5] && f7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLTU;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = f7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
    endcase
  end

  // Immediate extend
  always_comb begin
    imm32 = '0;
    case (imm_src)
      IMM_I:   imm32 = {{20{InstrD[31]}}, InstrD[31:20]};
      IMM_S:   imm32 = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   imm32 = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      IMM_J:   imm32 = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      IMM_U:   imm32 = {InstrD[31:12], 12'b0};
      default: imm32 = '0;
    endcase
  end

  // Register file; entry 0 is never written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[REG_AW'(i)] <= '0;
    end else if (RegWriteW && RDW != '0) begin
      regs[RDW] <= ResultW;
    end
  end

  always_comb begin
    rd1_d = (rs1_d == '0) ? '0 : regs[rs1_d];
    rd2_d = (rs2_d == '0) ? '0 : regs[rs2_d];
`ifdef ID_WB_BYPASS_EN
    if (RegWriteW && RDW != '0 && RDW == rs1_d) rd1_d = ResultW;
    if (RegWriteW && RDW != '0 && RDW == rs2_d) rd2_d = ResultW;
`endif
  end

  // Both sources are compared even when the opcode has no rs2
  assign load_use = q.valid && q.result_src && q.reg_write && q.rd != '0 &&
                    (q.rd == rs1_d || q.rd == rs2_d);
  assign StallD   = (load_use || HoldE) && !FlushE;

  always_comb begin
    d            = '0;
    d.valid      = 1'b1;
    d.branch     = branch;
    d.result_src = result_src;
    d.mem_write  = mem_write;
    d.reg_write  = reg_write;
    d.alu_src    = alu_src;
    d.alu_ctrl   = alu_ctrl;
    d.rs1        = rs1_d;
    d.rs2        = rs2_d;
    d.rd         = rd_d;
    d.rd1        = rd1_d;
    d.rd2        = rd2_d;
    d.imm        = XLEN'($signed(imm32));
    d.pc         = PCD;
  end

  // ID/EX register: flush beats hold, hold beats bubble/load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (FlushE) begin
      q <= '0;
    end else if (!HoldE) begin
      if (load_use || !ValidD) q <= '0;
      else                     q <= d;
    end
  end

  assign ValidE      = q.valid;
  assign BranchE     = q.branch;
  assign ResultSrcE  = q.result_src;
  assign MemWriteE   = q.mem_write;
  assign RegWriteE   = q.reg_write;
  assign ALUSrcE     = q.alu_src;
  assign ALUControlE = q.alu_ctrl;
  assign RS1E        = q.rs1;
  assign RS2E        = q.rs2;
  assign RDE         = q.rd;
  assign RD1E        = q.rd1;
  assign RD2E        = q.rd2;
  assign ImmExtE     = q.imm;
  assign PCE         = q.pc;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Directed bench for decode_stage_hz: RV32I instance plus a REG_AW=4 / XLEN=64 instance.
module tb_decode_stage_hz;
  localparam logic [31:0] LW_X5   = 32'h0001_2283; // lw   x5, 0(x2)
  localparam logic [31:0] ADD_651 = 32'h0012_8333; // add  x6, x5, x1
  localparam logic [31:0] ADDI_M1 = 32'hFFF0_0193; // addi x3, x0, -1
  localparam logic [31:0] ADD_870 = 32'h0003_8433; // add  x8, x7, x0
  localparam logic [31:0] ADD_800 = 32'h0000_0433; // add  x8, x0, x0
  localparam logic [31:0] ADD_871 = 32'h0013_8433; // add  x8, x7, x1

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic        ValidD, RegWriteW, FlushE, HoldE;
  logic [4:0]  RDW;
  logic [31:0] ResultW;
  logic        StallD, ValidE, BranchE, ResultSrcE, MemWriteE, RegWriteE, ALUSrcE;
  logic [3:0]  ALUControlE;
  logic [4:0]  RS1E, RS2E, RDE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE;

  logic [63:0] pc2;
  logic        stall2, valid2, br2, rs2e, mw2, rw2, as2;
  logic [3:0]  alu2, rs1e2, rs2e2, rde2;
  logic [63:0] rd1e2, rd2e2, imm2, pce2;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_byp;

  always #5 clk = ~clk;

  decode_stage_hz #(.XLEN(32), .REG_AW(5)) u_dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .ValidD(ValidD),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE), .HoldE(HoldE),
    .StallD(StallD), .ValidE(ValidE), .BranchE(BranchE), .ResultSrcE(ResultSrcE),
    .MemWriteE(MemWriteE), .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .RS1E(RS1E), .RS2E(RS2E), .RDE(RDE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE)
  );

  decode_stage_hz #(.XLEN(64), .REG_AW(4)) u_e (
    .clk(clk), .rst(rst), .InstrD(ADDI_M1), .PCD(pc2), .ValidD(1'b1),
    .RegWriteW(1'b0), .RDW(4'd0), .ResultW(64'd0), .FlushE(1'b0), .HoldE(1'b0),
    .StallD(stall2), .ValidE(valid2), .BranchE(br2), .ResultSrcE(rs2e),
    .MemWriteE(mw2), .RegWriteE(rw2), .ALUSrcE(as2), .ALUControlE(alu2),
    .RS1E(rs1e2), .RS2E(rs2e2), .RDE(rde2), .RD1E(rd1e2), .RD2E(rd2e2), .ImmExtE(imm2), .PCE(pce2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; InstrD = '0; PCD = '0; ValidD = 1'b0; RegWriteW = 1'b0; RDW = '0;
    ResultW = '0; FlushE = 1'b0; HoldE = 1'b0; pc2 = 64'h8000_0000_0000_0010;
    #1;
    chk("rst_valid", 64'(ValidE), 64'd0);
    chk("rst_pc", 64'(PCE), 64'd0);
    chk("rst_rd1", 64'(RD1E), 64'd0);
    chk("rst_stall", 64'(StallD), 64'd0);
    tick();
    rst = 1'b1;

    // Preload x1, x2, x7 through the writeback port with no valid instruction
    RegWriteW = 1'b1; RDW = 5'd1; ResultW = 32'h11; tick();
    chk("bubble_valid", 64'(ValidE), 64'd0);
    RDW = 5'd2; ResultW = 32'h100; tick();
    RDW = 5'd7; ResultW = 32'h1234; tick();
    RegWriteW = 1'b0;

    // RV32E / 64-bit instance: addi x3,x0,-1
    chk("e64_imm", imm2, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("e64_rd", 64'(rde2), 64'd3);
    chk("e64_pc", pce2, 64'h8000_0000_0000_0010);

    // Load into E
    InstrD = LW_X5; PCD = 32'h100; ValidD = 1'b1;
    #1 chk("lw_stall", 64'(StallD), 64'd0);
    tick();
    chk("lw_valid", 64'(ValidE), 64'd1);
    chk("lw_ctrl", 64'({ResultSrcE, RegWriteE, ALUSrcE, MemWriteE, BranchE}), 64'b11100);
    chk("lw_rd", 64'(RDE), 64'd5);
    chk("lw_rd1", 64'(RD1E), 64'h100);
    chk("lw_pc", 64'(PCE), 64'h100);

    // Load-use: one stall, one bubble, then the add passes
    InstrD = ADD_651; PCD = 32'h104;
    #1 chk("lu_stall", 64'(StallD), 64'd1);
    tick();
    chk("lu_bubble", 64'(ValidE), 64'd0);
    chk("lu_bub_rw", 64'(RegWriteE), 64'd0);
    chk("lu_stall2", 64'(StallD), 64'd0);
    tick();
    chk("lu_valid", 64'(ValidE), 64'd1);
    chk("lu_rs1", 64'(RS1E), 64'd5);
    chk("lu_rs2", 64'(RS2E), 64'd1);
    chk("lu_rd2", 64'(RD2E), 64'h11);
    chk("lu_ctrl", 64'({ResultSrcE, RegWriteE, ALUSrcE, ALUControlE}), 64'b0100000);
    chk("lu_pc", 64'(PCE), 64'h104);

    // Flush beats hold
    InstrD = ADDI_M1; PCD = 32'h108; FlushE = 1'b1; HoldE = 1'b1;
    #1 chk("fl_stall", 64'(StallD), 64'd0);
    tick();
    chk("fl_valid", 64'(ValidE), 64'd0);
    chk("fl_rw", 64'(RegWriteE), 64'd0);
    chk("fl_pc", 64'(PCE), 64'd0);

    // Hold: load addi, freeze three cycles, then release
    FlushE = 1'b0; HoldE = 1'b0; PCD = 32'h10C;
    tick();
    chk("addi_imm", 64'(ImmExtE), 64'hFFFF_FFFF);
    chk("addi_rd", 64'(RDE), 64'd3);
    InstrD = ADD_870; PCD = 32'h110; HoldE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_stall", 64'(StallD), 64'd1);
      tick();
      chk("hold_pc", 64'(PCE), 64'h10C);
      chk("hold_rd", 64'(RDE), 64'd3);
      chk("hold_valid", 64'(ValidE), 64'd1);
    end
    HoldE = 1'b0;
    #1 chk("rel_stall", 64'(StallD), 64'd0);
    tick();
    chk("rel_pc", 64'(PCE), 64'h110);
    chk("rel_rd", 64'(RDE), 64'd8);
    chk("rel_rd1", 64'(RD1E), 64'h1234);

    // Same-cycle writeback read of x7
    RegWriteW = 1'b1; RDW = 5'd7; ResultW = 32'hDEAD_BEEF;
`ifdef ID_WB_BYPASS_EN
    exp_byp = 32'hDEAD_BEEF;
`else
    exp_byp = 32'h1234;
`endif
    tick();
    chk("byp_rd1", 64'(RD1E), 64'(exp_byp));
    // Writes to x0 are ignored and never bypassed
    RDW = 5'd0; ResultW = 32'h5555; InstrD = ADD_800;
    tick();
    chk("x0_rd1", 64'(RD1E), 64'd0);
    InstrD = ADD_870;
    tick();
    chk("x0_rs7", 64'(RD1E), 64'hDEAD_BEEF);
    RegWriteW = 1'b0;
    InstrD = ADD_800;
    tick();
    chk("x0_after", 64'(RD1E), 64'd0);

    // Load-use together with flush: bubble without stall
    InstrD = LW_X5; PCD = 32'h200;
    tick();
    InstrD = ADD_651; PCD = 32'h204; FlushE = 1'b1;
    #1 chk("lufl_stall", 64'(StallD), 64'd0);
    tick();
    chk("lufl_valid", 64'(ValidE), 64'd0);
    FlushE = 1'b0;

    // Asynchronous reset in the middle of a load-use stall
    InstrD = LW_X5; PCD = 32'h300;
    tick();
    InstrD = ADD_651; PCD = 32'h304;
    #1 chk("rs_stall_pre", 64'(StallD), 64'd1);
    #1 rst = 1'b0;
    #1;
    chk("rs_valid", 64'(ValidE), 64'd0);
    chk("rs_ctrl", 64'({ResultSrcE, RegWriteE, ALUSrcE}), 64'd0);
    chk("rs_rd", 64'(RDE), 64'd0);
    chk("rs_pc", 64'(PCE), 64'd0);
    chk("rs_rs1", 64'(RS1E), 64'd0);
    chk("rs_stall", 64'(StallD), 64'd0);
    chk("rs_e64", 64'(valid2), 64'd0);
    tick();
    rst = 1'b1;
    InstrD = ADD_871; PCD = 32'h308;
    tick();
    chk("post_valid", 64'(ValidE), 64'd1);
    chk("post_rs1", 64'(RS1E), 64'd7);
    chk("post_rd1", 64'(RD1E), 64'd0);
    chk("post_rd2", 64'(RD2E), 64'd0);
    chk("post_e64_imm", imm2, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
